// File: rtl/jcmd_ep2_out_buffer.sv
// rtl/jcmd_ep2_out_buffer.sv - EP2 OUT packet buffer: captures one bulk OUT packet and holds it until released.
module jcmd_ep2_out_buffer #(
   parameter int MAX_LEN = 512,
   parameter int AW      = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   input  logic          rx_eop,
   input  logic          rx_abort,
   output logic          out_ready,
   output logic          buf_out_hasdata,
   output logic [9:0]    buf_out_len,
   input  logic [AW-1:0] buf_out_addr,
   output logic [7:0]    buf_out_q,
   input  logic          buf_out_arm,
   output logic          buf_out_arm_ack,
   output logic          err_overflow
);
   localparam int ABITS = $clog2(MAX_LEN);
   localparam logic [9:0] MAX_CNT = 10'(MAX_LEN);

   typedef enum logic [1:0] {FILL, HOLD, ACK} state_t;

   state_t           state;
   logic [7:0]       mem [MAX_LEN];
   logic [9:0]       wptr;
   logic             arm_q;
   logic             arm_prev;
   logic [ABITS-1:0] rd_addr;
   logic [7:0]       ram_q;
   logic             accept;
   logic             arm_rise;
   logic [9:0]       count_with_byte;
   logic             unused_addr_hi;

   assign accept          = (state == FILL) && rx_valid && (wptr != MAX_CNT);
   assign arm_rise        = arm_q && !arm_prev;
   assign count_with_byte = wptr + {9'd0, accept};
   // Upper address bits alias back onto the buffer (address mod MAX_LEN).
   assign unused_addr_hi  = ^buf_out_addr[AW-1:ABITS];

   always_ff @(posedge clk) begin
      if (reset && accept)
         mem[wptr[ABITS-1:0]] <= rx_data;
      ram_q <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= FILL;
         wptr            <= 10'd0;
         buf_out_len     <= 10'd0;
         buf_out_hasdata <= 1'b0;
         buf_out_arm_ack <= 1'b0;
         out_ready       <= 1'b0;
         err_overflow    <= 1'b0;
         arm_q           <= 1'b0;
         arm_prev        <= 1'b0;
         rd_addr         <= '0;
         buf_out_q       <= 8'd0;
      end else begin
         arm_q           <= buf_out_arm;
         arm_prev        <= arm_q;
         rd_addr         <= buf_out_addr[ABITS-1:0];
         buf_out_q       <= ram_q;
         buf_out_arm_ack <= 1'b0;
         if (state == FILL && rx_valid && wptr == MAX_CNT)
            err_overflow <= 1'b1;
         case (state)
            FILL: begin
               out_ready <= 1'b1;
               if (rx_abort)
                  wptr <= 10'd0;
               else
                  wptr <= count_with_byte;
               // A release request outranks completing the packet; the partial count survives.
               if (arm_rise) begin
                  state           <= ACK;
                  buf_out_arm_ack <= 1'b1;
                  out_ready       <= 1'b0;
               end else if (!rx_abort && rx_eop && count_with_byte != 10'd0) begin
                  state           <= HOLD;
                  buf_out_len     <= count_with_byte;
                  buf_out_hasdata <= 1'b1;
                  out_ready       <= 1'b0;
               end
            end
            HOLD: begin
               out_ready <= 1'b0;
               if (arm_rise) begin
                  state           <= ACK;
                  buf_out_arm_ack <= 1'b1;
                  buf_out_hasdata <= 1'b0;
                  wptr            <= 10'd0;
               end
            end
            ACK: begin
               state     <= FILL;
               out_ready <= 1'b1;
            end
            default: begin
               state     <= FILL;
               out_ready <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_jcmd_ep2_out_buffer.sv
// tb/tb_jcmd_ep2_out_buffer.sv - self-checking bench for jcmd_ep2_out_buffer against a packet-level model.
module tb_jcmd_ep2_out_buffer;
   localparam int MAX_LEN = 512;
   localparam int AW      = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_eop;
   logic          rx_abort;
   logic          out_ready;
   logic          buf_out_hasdata;
   logic [9:0]    buf_out_len;
   logic [AW-1:0] buf_out_addr;
   logic [7:0]    buf_out_q;
   logic          buf_out_arm;
   logic          buf_out_arm_ack;
   logic          err_overflow;

   int total = 0;
   int bad   = 0;

   logic [7:0] ref_mem [MAX_LEN];
   int         ref_cnt;
   bit         ref_hold;
   int         ref_len;
   bit         ref_ovf;
   logic [7:0] pkt [$];

   jcmd_ep2_out_buffer #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_eop(rx_eop), .rx_abort(rx_abort), .out_ready(out_ready),
      .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len),
      .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_arm(buf_out_arm),
      .buf_out_arm_ack(buf_out_arm_ack), .err_overflow(err_overflow)
   );

   always #10 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      ref_cnt = 0; ref_hold = 0; ref_len = 0; ref_ovf = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (ref_hold) return;
      if (ref_cnt < MAX_LEN) begin
         ref_mem[ref_cnt] = b;
         ref_cnt++;
      end else
         ref_ovf = 1;
   endtask

   task automatic model_eop();
      if (!ref_hold && ref_cnt > 0) begin
         ref_hold = 1;
         ref_len  = ref_cnt;
      end
   endtask

   task automatic drive_cycle(input bit v, input logic [7:0] d, input bit e, input bit a);
      rx_valid = v; rx_data = d; rx_eop = e; rx_abort = a;
      if (a) begin
         if (!ref_hold) ref_cnt = 0;
      end else begin
         if (v) model_byte(d);
         if (e) model_eop();
      end
      tick();
      rx_valid = 0; rx_eop = 0; rx_abort = 0;
   endtask

   task automatic send_pkt(input bit sep_eop, input bit gaps);
      for (int i = 0; i < pkt.size(); i++) begin
         if (gaps && $urandom_range(0, 2) == 0) drive_cycle(0, 8'h00, 0, 0);
         drive_cycle(1, pkt[i], (i == pkt.size() - 1) && !sep_eop, 0);
      end
      if (sep_eop) drive_cycle(0, 8'h00, 1, 0);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_hasdata"}, buf_out_hasdata, ref_hold);
      chk({tag, "_len"}, buf_out_len, ref_len);
      chk({tag, "_out_ready"}, out_ready, !ref_hold);
      chk({tag, "_err"}, err_overflow, ref_ovf);
   endtask

   task automatic read_chk(input string tag, input int addr);
      buf_out_addr = AW'(addr);
      tick(); tick(); tick();
      chk(tag, buf_out_q, ref_mem[addr % MAX_LEN]);
   endtask

   task automatic release_buf(input string tag);
      bit was_hold;
      int pulses;
      was_hold = ref_hold;
      pulses = 0;
      buf_out_arm = 1;
      tick();
      chk({tag, "_ack_early"}, buf_out_arm_ack, 0);
      chk({tag, "_hasdata_early"}, buf_out_hasdata, was_hold);
      tick();
      chk({tag, "_ack"}, buf_out_arm_ack, 1);
      chk({tag, "_hasdata_clr"}, buf_out_hasdata, 0);
      chk({tag, "_ready_in_ack"}, out_ready, 0);
      if (ref_hold) begin
         ref_hold = 0;
         ref_cnt  = 0;
      end
      tick();
      chk({tag, "_ack_end"}, buf_out_arm_ack, 0);
      chk({tag, "_ready_back"}, out_ready, 1);
      for (int i = 0; i < 7; i++) begin
         tick();
         if (buf_out_arm_ack) pulses++;
      end
      chk({tag, "_no_retrigger"}, pulses, 0);
      buf_out_arm = 0;
      tick();
   endtask

   initial begin
      reset = 0; rx_data = 0; rx_valid = 0; rx_eop = 0; rx_abort = 0;
      buf_out_addr = 0; buf_out_arm = 0;
      model_reset();
      tick(); tick(); tick();
      chk("rst_out_ready", out_ready, 0);
      chk("rst_hasdata", buf_out_hasdata, 0);
      chk("rst_len", buf_out_len, 0);
      chk("rst_ack", buf_out_arm_ack, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_q", buf_out_q, 0);
      reset = 1;
      tick();
      chk_state("post_rst");

      // Basic capture
      pkt = '{8'h0A, 8'h50, 8'h33};
      send_pkt(0, 0);
      chk_state("basic");
      chk("basic_len_const", buf_out_len, 3);
      for (int a = 0; a < 3; a++) read_chk("basic_rd", a);

      release_buf("rel1");
      pkt = '{8'h11};
      send_pkt(0, 0);
      chk_state("one_byte");
      read_chk("one_byte_rd", 0);
      release_buf("rel2");

      // Abort, then a fresh packet
      for (int i = 0; i < 5; i++) drive_cycle(1, 8'($urandom), 0, 0);
      drive_cycle(0, 8'h00, 0, 1);
      chk_state("abort");
      pkt = '{8'h22};
      send_pkt(0, 0);
      chk_state("after_abort");
      read_chk("after_abort_rd", 0);
      release_buf("rel3");

      // Zero-length packet
      drive_cycle(0, 8'h00, 1, 0);
      tick();
      chk_state("zlp");

      // Release requested in FILL keeps the partial packet
      drive_cycle(1, 8'hA1, 0, 0);
      drive_cycle(1, 8'hA2, 0, 0);
      release_buf("rel_fill");
      drive_cycle(1, 8'hA3, 1, 0);
      chk_state("partial_kept");
      chk("partial_len_const", buf_out_len, 3);
      for (int a = 0; a < 3; a++) read_chk("partial_rd", a);
      release_buf("rel4");

      // Randomized packets
      for (int p = 0; p < 5; p++) begin
         int n;
         n = $urandom_range(1, 40);
         pkt.delete();
         for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
         send_pkt($urandom_range(0, 1) == 1, 1);
         chk_state("rnd");
         for (int r = 0; r < 4; r++) read_chk("rnd_rd", $urandom_range(0, n - 1));
         if (p == 2) begin
            for (int i = 0; i < 4; i++) drive_cycle(1, 8'hEE, i == 3, 0);
            chk_state("held");
            chk("held_len_const", buf_out_len, n);
            for (int a = 0; a < n; a++) read_chk("held_rd", a);
         end
         release_buf("rel_rnd");
      end

      // Overflow
      for (int i = 0; i < 600; i++) drive_cycle(1, 8'(i % 256), i == 599, 0);
      chk_state("ovf");
      chk("ovf_len_const", buf_out_len, 512);
      chk("ovf_err_const", err_overflow, 1);
      buf_out_addr = 11'd511;
      tick(); tick(); tick();
      chk("ovf_rd511", buf_out_q, 8'hFF);
      buf_out_addr = 11'd512;
      tick(); tick(); tick();
      chk("ovf_rd512_alias", buf_out_q, 8'h00);
      release_buf("rel_ovf");
      chk("ovf_err_sticky", err_overflow, 1);

      // Reset during byte 2 of a packet
      drive_cycle(1, 8'h5A, 0, 0);
      rx_valid = 1; rx_data = 8'h6B; reset = 0;
      tick();
      rx_valid = 0;
      model_reset();
      chk("rst_mid_ready", out_ready, 0);
      chk("rst_mid_hasdata", buf_out_hasdata, 0);
      chk("rst_mid_len", buf_out_len, 0);
      chk("rst_mid_err", err_overflow, 0);
      chk("rst_mid_q", buf_out_q, 0);
      reset = 1;
      tick();
      chk("rst_mid_ready_after", out_ready, 1);
      pkt = '{8'hC3, 8'h3C};
      send_pkt(0, 0);
      chk_state("rst_mid_pkt");
      read_chk("rst_mid_rd0", 0);
      read_chk("rst_mid_rd1", 1);

      // Reset while the ack pulse is high
      buf_out_arm = 1;
      tick(); tick();
      chk("rst_ack_pre", buf_out_arm_ack, 1);
      reset = 0; buf_out_arm = 0;
      tick();
      model_reset();
      chk("rst_ack_ack", buf_out_arm_ack, 0);
      chk("rst_ack_hasdata", buf_out_hasdata, 0);
      chk("rst_ack_ready", out_ready, 0);
      chk("rst_ack_len", buf_out_len, 0);
      chk("rst_ack_q", buf_out_q, 0);
      reset = 1;
      tick();
      chk_state("rst_ack_after");
      pkt = '{8'h71, 8'h17};
      send_pkt(1, 0);
      chk_state("rst_ack_pkt");
      read_chk("rst_ack_rd1", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/jcmd_ep2_out_buffer.md
# jcmd_ep2_out_buffer

Packet buffer between the USB device core's EP2 OUT receive path and the Joker command processor. It captures one bulk OUT packet (a jcmd plus payload) into on-chip RAM and presents it to the consumer as a random-access byte array with a length. It holds the packet until the consumer releases it through the arm/ack handshake, and keeps the endpoint NAKing (`out_ready` low) while a packet is held.

## Interface
Parameters:
- `MAX_LEN`, 512: buffer capacity in bytes (power of two, ≤ 1023); bytes beyond it are dropped.
- `AW`, 11: consumer address width (`buf_out_addr`).

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-low.
- `rx_data`  in  8  received OUT byte from USB core.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_eop`  in  1  end of good packet (CRC ok); may coincide with the last `rx_valid`.
- `rx_abort`  in  1  discard packet in progress (CRC error, PID mismatch).
- `out_ready`  out  1  buffer can accept a packet; USB core NAKs when low.
- `buf_out_hasdata`  out  1  a complete packet is held.
- `buf_out_len`  out  10  byte count of the held packet.
- `buf_out_addr`  in  11  consumer read address.
- `buf_out_q`  out  8  read data.
- `buf_out_arm`  in  1  consumer releases the buffer (level, held until ack).
- `buf_out_arm_ack`  out  1  release acknowledge.
- `err_overflow`  out  1  sticky: a packet exceeded `MAX_LEN`; cleared only by reset.

## Operation
- **State FILL** (after reset):
  - `out_ready`=1, `buf_out_hasdata`=0.
  - Each `rx_valid` with `wptr < MAX_LEN` writes `mem[wptr]` and increments `wptr`.
  - If `wptr == MAX_LEN`, the byte is dropped and `err_overflow` is set.
- **FILL → HOLD** on `rx_eop` with final count > 0:
  - `buf_out_len` = final count. This includes a byte whose `rx_valid` coincides with `rx_eop`.
  - `len` saturates at `MAX_LEN`.
- **Zero-length packet** (`rx_eop` with count 0): ignored; stays in FILL, `wptr`=0.
- **`rx_abort` in FILL**: `wptr` ← 0; no HOLD. Abort wins over eop in the same cycle.
- **State HOLD**:
  - `out_ready`=0, `buf_out_hasdata`=1; `buf_out_len` stable.
  - `rx_valid`, `rx_eop` and `rx_abort` are ignored; RAM contents are frozen.
- **Rising edge of `buf_out_arm`** (arm=1, previous arm=0), any state: enter ACK.
  - From HOLD: `buf_out_hasdata` ← 0 and `wptr` ← 0 on entry.
  - From FILL: any partial packet is kept and FILL resumes after ACK.
- **State ACK**:
  - `buf_out_arm_ack`=1 for exactly one cycle; `out_ready`=0.
  - Then returns to FILL.
  - The consumer drops arm after seeing the ack falling edge; arm staying high does not re-trigger.
- **Read port**:
  - `buf_out_q` = `mem[buf_out_addr mod MAX_LEN]`.
  - Reads are legal in every state and do not disturb writes.
  - Addresses ≥ `buf_out_len` return stale RAM content.
- **Reset** (reset=0 at a clock edge), including mid-packet or mid-handshake:
  - State FILL, `wptr`=0, `buf_out_len`=0, `buf_out_hasdata`=0, `buf_out_arm_ack`=0, `out_ready`=0 during reset, `err_overflow`=0, `buf_out_q`=0.
  - The internal arm-previous register is cleared to 0.
  - RAM contents are not cleared.

## Timing
- **Write path:**
  - A byte presented at edge N is readable from edge N+1.
  - `buf_out_hasdata` and `buf_out_len` are registered and valid the cycle after the `rx_eop` edge.
  - `out_ready` falls in the same cycle as `hasdata` rises.
- **Read latency:** 2 clocks. The address is sampled at edge N into the RAM address register, and `buf_out_q` is valid after edge N+2 (registered RAM output). Consumers wait ≥3 cycles after changing the address.
- **Arm handshake:**
  - arm rises before edge N.
  - `buf_out_arm_ack`=1 after edge N+1 and 0 after edge N+2.
  - `hasdata`=0 after edge N+1; `out_ready`=1 after edge N+2.
- **Throughput:** one byte per clock on the write side.

## Test plan
- **Basic capture:** send 3-byte packet {0x0A,0x50,0x33} with eop on the last byte → `hasdata`=1 next cycle, `len`=3, `out_ready`=0. Reads at addr 0/1/2 return 0x0A/0x50/0x33 two cycles after each address change.
- **Release:** in HOLD raise arm and hold it for 10 cycles → a single 1-cycle `arm_ack` pulse one cycle after arm rises, `hasdata`=0, `out_ready`=1 one cycle later. Then drop arm and send a new 1-byte packet 0x11 → `len`=1, addr0=0x11.
- **Abort and ZLP:**
  - 5 bytes then `rx_abort` → no `hasdata`; next packet {0x22} yields `len`=1, addr0=0x22.
  - eop with no bytes → `hasdata` stays 0.
- **Overflow:** `MAX_LEN`=512, send 600 bytes (value = index mod 256) then eop → `len`=512, `err_overflow`=1, addr 511 reads 0xFF, addr 512 aliases addr 0 = 0x00.
- **Held-packet protection:** in HOLD drive 4 `rx_valid` bytes 0xEE plus eop → `len` and contents unchanged; `out_ready` stays 0.
- **Reset mid-operation:** assert reset=0 during byte 2 of a packet and separately during `arm_ack` → all outputs return to reset values next edge. After reset release `out_ready`=1 and a fresh 2-byte packet gives `len`=2.
